// File: rtl/snes_multipad_reader.sv
// -----------------------------------------------------------------------------
// snes_multipad_reader
//   Scans NUM_PADS SNES/NES controllers in parallel over one shared latch/clock
//   pair, one serial data line per pad. A scan is requested by a single-cycle
//   frame pulse or, when auto_en is set, every AUTO_PERIOD ticks. All pad
//   states are published together on the cycle done pulses, along with a
//   per-button "newly pressed" mask relative to the previous published scan.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   frame        in   single-cycle scan request
//   auto_en      in   1 = request a scan every AUTO_PERIOD ticks
//   nesl         out  shared latch to all pads (high for one tick period)
//   nesc         out  shared pad clock, idle high, low while sampling
//   nesd         in   serial data, bit i from pad i
//   pad_state    out  pad i at [i*NUM_BITS +: NUM_BITS], first-shifted bit MSB
//   pad_pressed  out  1 = button released last scan, pressed this scan
//   busy         out  high while a scan is in progress
//   done         out  one-clk pulse when pad_state/pad_pressed update
// -----------------------------------------------------------------------------
module snes_multipad_reader #(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BITS     = 16,
  parameter int CLK_DIV_BITS = 5,
  parameter int INVERT       = 0,
  parameter int AUTO_PERIOD  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame,
  input  logic                         auto_en,
  output logic                         nesl,
  output logic                         nesc,
  input  logic [NUM_PADS-1:0]          nesd,
  output logic [NUM_PADS*NUM_BITS-1:0] pad_state,
  output logic [NUM_PADS*NUM_BITS-1:0] pad_pressed,
  output logic                         busy,
  output logic                         done
);

  localparam int W      = NUM_PADS * NUM_BITS;
  localparam int CNT_W  = $clog2(NUM_BITS);
  localparam int AUTO_W = $clog2(AUTO_PERIOD);

  localparam logic              INV_BIT   = (INVERT != 0);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(NUM_BITS - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH_HI = 3'd1,
    S_LATCH_LO = 3'd2,
    S_CLOCK_LO = 3'd3,
    S_CLOCK_HI = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Converts stored bits to an active-high "pressed" view. With INVERT=0 the
  // stored value is the raw line level, where a low line means pressed.
  function automatic logic [W-1:0] f_pressed(input logic [W-1:0] v);
    return INV_BIT ? v : ~v;
  endfunction

  logic [CLK_DIV_BITS-1:0] r_clkdiv;
  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pending;
  logic [AUTO_W-1:0]       r_auto_cnt;
  logic [W-1:0]            r_sr;
  logic [W-1:0]            r_pad_state;
  logic [W-1:0]            r_pad_pressed;
  logic                    r_nesl;
  logic                    r_nesc;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_tick;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_start;
  logic                    w_sample;
  logic                    w_publish;
  logic                    w_auto_wrap;
  logic [W-1:0]            w_sr_next;

  assign w_tick      = &r_clkdiv;
  assign w_auto_wrap = w_tick & auto_en & (r_auto_cnt == AUTO_LAST);

  // Next-state and per-tick strobes; nothing advances between ticks.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_publish    = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            w_state_next = S_LATCH_HI;
            w_start      = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_LATCH_HI: w_state_next = S_LATCH_LO;
        S_LATCH_LO: w_state_next = S_CLOCK_LO;
        S_CLOCK_LO: begin
          // nesc has been low for a whole tick, so nesd is settled here.
          w_state_next = S_CLOCK_HI;
          w_sample     = 1'b1;
        end
        S_CLOCK_HI: begin
          if (r_cnt == LAST_BIT) begin
            w_state_next = S_DONE;
            w_publish    = 1'b1;
          end else begin
            w_state_next = S_CLOCK_LO;
            w_cnt_next   = r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
          w_cnt_next   = {CNT_W{1'b0}};
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Every pad shifts its own line in at the LSB; the first bit ends up at MSB.
  always_comb begin
    w_sr_next = r_sr;
    for (int i = 0; i < NUM_PADS; i++) begin
      w_sr_next[i*NUM_BITS +: NUM_BITS] = {r_sr[i*NUM_BITS +: NUM_BITS-1], nesd[i] ^ INV_BIT};
    end
  end

  // Tick divider, scan request latch and auto-poll counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clkdiv   <= {CLK_DIV_BITS{1'b0}};
      r_pending  <= 1'b0;
      r_auto_cnt <= {AUTO_W{1'b0}};
    end else begin
      r_clkdiv  <= r_clkdiv + CLK_DIV_BITS'(1);
      // A new request wins over the clear so it is never lost; requests
      // arriving during a scan collapse into this single flag.
      r_pending <= (r_pending & ~w_start) | frame | w_auto_wrap;
      if (!auto_en) begin
        r_auto_cnt <= {AUTO_W{1'b0}};
      end else if (w_tick) begin
        r_auto_cnt <= (r_auto_cnt == AUTO_LAST) ? {AUTO_W{1'b0}} : r_auto_cnt + AUTO_W'(1);
      end else begin
        r_auto_cnt <= r_auto_cnt;
      end
    end
  end

  // Scan state machine register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Shift registers plus the atomic publish of state and pressed edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr          <= {W{1'b0}};
      r_pad_state   <= {W{1'b0}};
      r_pad_pressed <= {W{1'b0}};
    end else begin
      r_sr <= w_sample ? w_sr_next : r_sr;
      if (w_publish) begin
        r_pad_state   <= r_sr;
        r_pad_pressed <= f_pressed(r_sr) & ~f_pressed(r_pad_state);
      end else begin
        r_pad_state   <= r_pad_state;
        r_pad_pressed <= r_pad_pressed;
      end
    end
  end

  // Pad-facing and status outputs, registered from the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nesl <= 1'b0;
      r_nesc <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_nesl <= (r_state == S_LATCH_HI);
      r_nesc <= (r_state != S_CLOCK_LO);
      r_busy <= (r_state != S_IDLE);
      r_done <= w_publish;
    end
  end

  assign nesl        = r_nesl;
  assign nesc        = r_nesc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pad_state   = r_pad_state;
  assign pad_pressed = r_pad_pressed;

endmodule
